alu_ctrl_mc: RTL and testbench
==============================

Name: alu_ctrl_mc

Overview:
Parametrised, registered successor to the single-cycle ALU control decoder. Decodes the main-control class (ctrl) and R-type funct field into an ALU operation code. Adds shifts, XOR/NOR, immediate classes, and multi-cycle MULT/DIV sequencing with a stall handshake toward the pipeline/PC logic. Sits between the main control unit and the ALU / HI-LO multiply-divide unit.

Parameters:
OP_W, 4, width of alu_op output code (minimum 4)
MUL_CYCLES, 4, busy cycles for MULT/MULTU (range 1-63)
DIV_CYCLES, 32, busy cycles for DIV/DIVU (range 1-63)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  ctrl/funct valid this cycle
in_ready  out  1  block accepts input (high when not busy)
ctrl  in  3  main-control op class
funct  in  6  instruction[5:0]
flush  in  1  abort in-flight op (branch/exception)
out_valid  out  1  alu_op valid, one-cycle pulse per accepted input
alu_op  out  OP_W  registered ALU operation code
md_start  out  1  one-cycle pulse starting multiply/divide unit
md_busy  out  1  multi-cycle op in progress (pipeline stall)
md_done  out  1  one-cycle pulse, HI/LO write enable
illegal  out  1  undecodable funct (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, alu_op=0, out_valid=0, md_start=0, md_busy=0, md_done=0, illegal=0, in_ready=1 after release.
- Accept = in_valid & in_ready, sampled at rising edge; decode registered, out_valid and alu_op appear one cycle later (latency 1).
- ctrl decode: 000 R-type (funct table); 001 LW ->ADD; 010 SW ->ADD; 011 BEQ ->SUB; 100 BNE ->SUB; 101 J ->0111; 110 ADDI ->ADD; 111 SLTI ->SLT.
- funct table (ctrl=000): 100000 ADD 0000; 100010 SUB 0001; 100100 AND 0010; 100101 OR 0011; 101010 SLT 0100; 100110 XOR 0101; 100111 NOR 0110; 000000 SLL 1000; 000010 SRL 1001; 011000 MULT 1010; 011001 MULTU 1010; 011010 DIV 1011; 011011 DIVU 1011; other -> illegal handling.
- Codes zero-extended to OP_W.
- FSM IDLE/BUSY/DONE:
  - IDLE: accept of MULT*/DIV* -> BUSY, md_start=1 and out_valid=1 next cycle, counter loaded with MUL_CYCLES-1 or DIV_CYCLES-1, md_busy=1, in_ready=0.
  - BUSY: counter decrements each cycle; at 0 -> DONE.
  - DONE: md_done=1 for exactly one cycle, md_busy=0, in_ready=1, return to IDLE; an input accepted in DONE is decoded normally.
- Single-cycle ops never leave IDLE; back-to-back accepts give out_valid every cycle.
- flush: in BUSY/DONE returns to IDLE next edge, md_busy=0, no md_done; flush with in_valid in IDLE drops the input (no out_valid). flush outranks accept.
- Busy length: md_busy high exactly N cycles (N = MUL_CYCLES or DIV_CYCLES), starting the cycle md_start is high; md_done on cycle N+1.
- rst mid-operation: immediate abort, all outputs to reset values, no md_done.
- alu_op holds its last value when out_valid=0.

Optional Feature:
ALU_CTRL_TRAP_EN
- Defined: undecodable funct gives alu_op=all ones, illegal=1 with out_valid, sticky until next accepted legal input or rst.
- Undefined: undecodable funct decodes to ADD (0000), illegal tied 0.

Test Plan:
- Reset then ctrl=000, funct=100010, in_valid 1 cycle -> next cycle out_valid=1, alu_op=0001, md_busy=0.
- ctrl sweep 001..111 back-to-back -> alu_op 0000,0000,0001,0001,0111,0000,0100 on consecutive cycles.
- funct=011000, MUL_CYCLES=4 -> md_start pulse, md_busy high 4 cycles, in_ready low, md_done pulse cycle 5, next input accepted cycle 5.
- DIV (011010), flush at busy cycle 10 -> md_busy drops next cycle, no md_done, in_ready=1.
- rst asserted at busy cycle 2 of MULT -> all outputs 0 immediately, state IDLE.
- funct=111111: with ALU_CTRL_TRAP_EN alu_op=1111, illegal=1 until legal ADD accepted; without, alu_op=0000, illegal=0.

Source files
------------

// File: rtl/alu_ctrl_mc.sv
// Registered ALU control decoder with multi-cycle MULT/DIV sequencing and stall handshake.
// Optional macro ALU_CTRL_TRAP_EN: undecodable R-type funct traps (alu_op all ones, sticky illegal).
module alu_ctrl_mc #(
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ctrl,
    input  logic [5:0]      funct,
    input  logic            flush,
    output logic            out_valid,
    output logic [OP_W-1:0] alu_op,
    output logic            md_start,
    output logic            md_busy,
    output logic            md_done,
    output logic            illegal
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_J   = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       is_mul;
        logic       is_div;
        logic       bad;
    } dec_t;

    function automatic dec_t decode_op(input logic [2:0] c, input logic [5:0] f);
        dec_t d;
        d.code   = OP_ADD;
        d.is_mul = 1'b0;
        d.is_div = 1'b0;
        d.bad    = 1'b0;
        case (c)
            3'b000: begin
                case (f)
                    6'b100000: d.code = OP_ADD;
                    6'b100010: d.code = OP_SUB;
                    6'b100100: d.code = OP_AND;
                    6'b100101: d.code = OP_OR;
                    6'b101010: d.code = OP_SLT;
                    6'b100110: d.code = OP_XOR;
                    6'b100111: d.code = OP_NOR;
                    6'b000000: d.code = OP_SLL;
                    6'b000010: d.code = OP_SRL;
                    6'b011000, 6'b011001: begin
                        d.code   = OP_MUL;
                        d.is_mul = 1'b1;
                    end
                    6'b011010, 6'b011011: begin
                        d.code   = OP_DIV;
                        d.is_div = 1'b1;
                    end
                    default: d.bad = 1'b1;
                endcase
            end
            3'b001, 3'b010, 3'b110: d.code = OP_ADD;
            3'b011, 3'b100:         d.code = OP_SUB;
            3'b101:                 d.code = OP_J;
            3'b111:                 d.code = OP_SLT;
            default:                d.code = OP_ADD;
        endcase
        return d;
    endfunction

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic            out_valid_q, out_valid_d;
    logic            md_start_q, md_start_d;
    logic            md_busy_q, md_busy_d;
    logic            md_done_q, md_done_d;
    logic            illegal_q, illegal_d;
    logic            accept_s;
    dec_t            dec_s;

    // Flush outranks a new input; nothing is taken while a multi-cycle op is running.
    assign accept_s = in_valid & ~md_busy_q & ~flush;
    assign dec_s    = decode_op(ctrl, funct);

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_op_d    = alu_op_q;
        out_valid_d = 1'b0;
        md_start_d  = 1'b0;
        md_done_d   = 1'b0;
        illegal_d   = illegal_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d   = ST_DONE;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            out_valid_d = 1'b1;
`ifdef ALU_CTRL_TRAP_EN
            alu_op_d  = dec_s.bad ? {OP_W{1'b1}} : OP_W'(dec_s.code);
            illegal_d = dec_s.bad;
`else
            alu_op_d  = dec_s.bad ? OP_W'(OP_ADD) : OP_W'(dec_s.code);
            illegal_d = 1'b0;
`endif
            if (dec_s.is_mul) begin
                state_d    = ST_BUSY;
                cnt_d      = MUL_LOAD;
                md_start_d = 1'b1;
            end else if (dec_s.is_div) begin
                state_d    = ST_BUSY;
                cnt_d      = DIV_LOAD;
                md_start_d = 1'b1;
            end else begin
                md_start_d = 1'b0;
            end
        end else begin
            out_valid_d = 1'b0;
        end

        md_busy_d = (state_d == ST_BUSY);
    end

    // Sequencer state and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            alu_op_q    <= {OP_W{1'b0}};
            out_valid_q <= 1'b0;
            md_start_q  <= 1'b0;
            md_busy_q   <= 1'b0;
            md_done_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_op_q    <= alu_op_d;
            out_valid_q <= out_valid_d;
            md_start_q  <= md_start_d;
            md_busy_q   <= md_busy_d;
            md_done_q   <= md_done_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = ~md_busy_q;
    assign out_valid = out_valid_q;
    assign alu_op    = alu_op_q;
    assign md_start  = md_start_q;
    assign md_busy   = md_busy_q;
    assign md_done   = md_done_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed scenarios plus randomized traffic vs a cycle-timeline model.
module tb_alu_ctrl_mc;

    localparam int OP_W       = 4;
    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;
`ifdef ALU_CTRL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      ctrl = 3'd0;
    logic [5:0]      funct = 6'd0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic [OP_W-1:0] alu_op;
    logic            md_start, md_busy, md_done, illegal;

    int tests = 0;
    int fails = 0;

    int ctrl_tbl [8] = '{-1, 0, 0, 1, 1, 7, 0, 4};
    int fmap [int];
    int legal_f [13] = '{32, 34, 36, 37, 42, 38, 39, 0, 2, 24, 25, 26, 27};

    alu_ctrl_mc #(.OP_W(OP_W), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .funct(funct), .flush(flush), .out_valid(out_valid),
        .alu_op(alu_op), .md_start(md_start), .md_busy(md_busy),
        .md_done(md_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_op(input int c, input int f);
        if (c != 0) return ctrl_tbl[c];
        if (fmap.exists(f)) return fmap[f];
        return -1;
    endfunction

    function automatic int md_len(input int c, input int f);
        if (c == 0 && (f == 24 || f == 25)) return MUL_CYCLES;
        if (c == 0 && (f == 26 || f == 27)) return DIV_CYCLES;
        return 0;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++; if (alu_op !== 4'h0) begin fails++; $display("FAIL reset_alu_op got %0h want 0", alu_op); end
        tests++; if ({md_start, md_busy, md_done, illegal} !== 4'b0000) begin fails++; $display("FAIL reset_md got %b want 0000", {md_start, md_busy, md_done, illegal}); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_rtype_sub();
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b100010;
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sub_out_valid got %0b want 1", out_valid); end
        tests++; if (alu_op !== 4'h1) begin fails++; $display("FAIL sub_alu_op got %0h want 1", alu_op); end
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL sub_md_busy got %0b want 0", md_busy); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sub_pulse got %0b want 0", out_valid); end
        tests++; if (alu_op !== 4'h1) begin fails++; $display("FAIL sub_hold got %0h want 1", alu_op); end
    endtask

    task automatic test_ctrl_sweep();
        logic [3:0] exp [7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h7, 4'h0, 4'h4};
        for (int k = 1; k <= 7; k++) begin
            in_valid = 1'b1; ctrl = 3'(k); funct = 6'h3F;
            step();
            tests++; if (out_valid !== 1'b1 || alu_op !== exp[k-1]) begin
                fails++; $display("FAIL sweep_ctrl%0d got v=%0b op=%0h want v=1 op=%0h", k, out_valid, alu_op, exp[k-1]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush_idle();
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b100100; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_idle_out_valid got %0b want 0", out_valid); end
        tests++; if (alu_op !== 4'h4) begin fails++; $display("FAIL flush_idle_hold got %0h want 4", alu_op); end
    endtask

    task automatic test_mult();
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b011000;
        step();
        for (int i = 1; i <= MUL_CYCLES; i++) begin
            tests++; if (md_busy !== 1'b1 || in_ready !== 1'b0 || md_done !== 1'b0) begin
                fails++; $display("FAIL mult_busy_c%0d got busy=%0b rdy=%0b done=%0b want 1 0 0", i, md_busy, in_ready, md_done);
            end
            tests++; if (md_start !== (i == 1) || out_valid !== (i == 1)) begin
                fails++; $display("FAIL mult_start_c%0d got start=%0b ov=%0b want %0b", i, md_start, out_valid, (i == 1));
            end
            if (i == 1) begin
                tests++; if (alu_op !== 4'hA) begin fails++; $display("FAIL mult_alu_op got %0h want a", alu_op); end
                in_valid = 1'b1; funct = 6'b100000;
            end
            step();
        end
        tests++; if (md_done !== 1'b1 || md_busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL mult_done got done=%0b busy=%0b rdy=%0b ov=%0b want 1 0 1 0", md_done, md_busy, in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || alu_op !== 4'h0 || md_done !== 1'b0) begin
            fails++; $display("FAIL mult_next_accept got ov=%0b op=%0h done=%0b want 1 0 0", out_valid, alu_op, md_done);
        end
        step();
    endtask

    task automatic test_div_flush();
        int bad = 0;
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b011010;
        step();
        in_valid = 1'b0;
        tests++; if (alu_op !== 4'hB || md_start !== 1'b1) begin fails++; $display("FAIL div_start got op=%0h start=%0b want b 1", alu_op, md_start); end
        repeat (9) step();
        tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL div_busy10 got %0b want 1", md_busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (md_busy !== 1'b0 || md_done !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL div_flush got busy=%0b done=%0b rdy=%0b want 0 0 1", md_busy, md_done, in_ready);
        end
        for (int i = 0; i < DIV_CYCLES + 8; i++) begin
            step();
            if (md_done !== 1'b0 || md_busy !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL div_flush_quiet got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_rst_mid();
        int bad = 0;
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b011001;
        step();
        in_valid = 1'b0;
        step();
        tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy got %0b want 1", md_busy); end
        rst = 1'b1;
        #1;
        tests++; if ({out_valid, md_start, md_busy, md_done, illegal} !== 5'b0 || alu_op !== 4'h0) begin
            fails++; $display("FAIL rstmid_clear got flags=%b op=%0h want 00000 0", {out_valid, md_start, md_busy, md_done, illegal}, alu_op);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < MUL_CYCLES + 4; i++) begin
            step();
            if (md_done !== 1'b0 || md_busy !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rstmid_idle got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_illegal();
        logic [3:0] exp_op = TRAP ? 4'hF : 4'h0;
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b111111;
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || alu_op !== exp_op || illegal !== TRAP) begin
            fails++; $display("FAIL illegal_decode got ov=%0b op=%0h ill=%0b want 1 %0h %0b", out_valid, alu_op, illegal, exp_op, TRAP);
        end
        in_valid = 1'b1; ctrl = 3'b101; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step();
        tests++; if (illegal !== TRAP || alu_op !== exp_op) begin
            fails++; $display("FAIL illegal_sticky got ill=%0b op=%0h want %0b %0h", illegal, alu_op, TRAP, exp_op);
        end
        in_valid = 1'b1; ctrl = 3'b000; funct = 6'b100000;
        step();
        in_valid = 1'b0;
        tests++; if (illegal !== 1'b0 || alu_op !== 4'h0 || out_valid !== 1'b1) begin
            fails++; $display("FAIL illegal_clear got ill=%0b op=%0h ov=%0b want 0 0 1", illegal, alu_op, out_valid);
        end
        step();
    endtask

    task automatic test_random();
        int c = 0;
        int busy_lo = 1, busy_hi = 0, done_at = -1;
        logic [OP_W-1:0] exp_op = '0;
        logic exp_ov = 1'b0, exp_st = 1'b0, exp_ill = 1'b0;
        bit exp_busy;
        for (int it = 0; it < 600; it++) begin
            bit v, fl, busy_now, acc;
            int cc, ff, r, n;
            v  = ($urandom_range(0, 3) != 0);
            cc = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
            ff = ($urandom_range(0, 9) < 8) ? legal_f[$urandom_range(0, 12)] : int'($urandom_range(0, 63));
            if (ff == 26 || ff == 27) ff = ($urandom_range(0, 3) == 0) ? ff : 32;
            fl = ($urandom_range(0, 24) == 0);
            in_valid = v; ctrl = 3'(cc); funct = 6'(ff); flush = fl;
            busy_now = (c >= busy_lo) && (c <= busy_hi);
            acc = v && !busy_now && !fl;
            exp_ov = acc;
            exp_st = 1'b0;
            if (fl && busy_now) begin
                busy_hi = c;
                done_at = -1;
            end
            if (acc) begin
                r = ref_op(cc, ff);
                if (r < 0) begin
                    exp_op  = TRAP ? {OP_W{1'b1}} : '0;
                    exp_ill = TRAP;
                end else begin
                    exp_op  = OP_W'(r);
                    exp_ill = 1'b0;
                end
                n = md_len(cc, ff);
                if (n > 0) begin
                    busy_lo = c + 1;
                    busy_hi = c + n;
                    done_at = c + n + 1;
                    exp_st  = 1'b1;
                end
            end
            step();
            c++;
            exp_busy = (c >= busy_lo) && (c <= busy_hi);
            tests++; if (out_valid !== exp_ov || alu_op !== exp_op) begin
                fails++; $display("FAIL rand_op c%0d got ov=%0b op=%0h want %0b %0h", c, out_valid, alu_op, exp_ov, exp_op);
            end
            tests++; if (md_start !== exp_st || md_busy !== exp_busy || in_ready !== !exp_busy || md_done !== (c == done_at)) begin
                fails++; $display("FAIL rand_md c%0d got st=%0b busy=%0b rdy=%0b done=%0b want %0b %0b %0b %0b",
                                  c, md_start, md_busy, in_ready, md_done, exp_st, exp_busy, !exp_busy, (c == done_at));
            end
            tests++; if (illegal !== exp_ill) begin
                fails++; $display("FAIL rand_illegal c%0d got %0b want %0b", c, illegal, exp_ill);
            end
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        fmap[32] = 0; fmap[34] = 1; fmap[36] = 2; fmap[37] = 3; fmap[42] = 4;
        fmap[38] = 5; fmap[39] = 6; fmap[0] = 8; fmap[2] = 9;
        fmap[24] = 10; fmap[25] = 10; fmap[26] = 11; fmap[27] = 11;
        test_reset();
        test_rtype_sub();
        test_ctrl_sweep();
        test_flush_idle();
        test_mult();
        test_div_flush();
        test_rst_mid();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
